sys_bus_arbiter: RTL and testbench

Two-master, multi-slave arbiter and sequencer for the processor system data bus. Shares the single peripheral/memory bus between the core's LSU (master 0) and a secondary master (master 1, e.g. UART loader or DMA) with round-robin grant. Decodes `addr[31:24]` into one-hot slave requests for data memory, PS/2 and VGA, and returns registered read data. Completes unmapped or stalled accesses with an error response.

---
 rtl/sys_bus_arbiter_if.sv | 46 ++++
 rtl/sys_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_bus_arbiter_if.sv
// System data bus bundle: two masters in, three slaves out.
// The arbiter takes the master modport, the surrounding system the slave one.
interface sys_bus_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wd_i;
  logic [31:0] m0_rd_o;
  logic        m0_ready_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wd_i;
  logic [31:0] m1_rd_o;
  logic        m1_ready_o;

  logic [2:0]  s_req_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wd_o;
  logic [31:0] s_addr_o;
  logic [31:0] s0_rd_i;
  logic [31:0] s1_rd_i;
  logic [31:0] s2_rd_i;
  logic [2:0]  s_ready_i;
  logic        err_o;

  modport master (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    input  s0_rd_i, s1_rd_i, s2_rd_i, s_ready_i,
    output m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    output s_req_o, s_we_o, s_be_o, s_wd_o, s_addr_o, err_o
  );

  modport slave (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wd_i,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i,
    output s0_rd_i, s1_rd_i, s2_rd_i, s_ready_i,
    input  m0_rd_o, m0_ready_o, m1_rd_o, m1_ready_o,
    input  s_req_o, s_we_o, s_be_o, s_wd_o, s_addr_o, err_o
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Round-robin two-master arbiter/sequencer for the system data bus.
// Optional BUS_TIMEOUT_EN aborts WAIT after TIMEOUT cycles with an error.
module sys_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic resetn_i,
  sys_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;

  logic [2:0]  hit;
  logic        hit_rdy;
  logic [31:0] hit_rd;
  logic        win;
  logic        resp;
  logic        rdy0, rdy1;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    hit = 3'b000;
    case (addr_q[31:24])
      8'h00:   hit = 3'b001;
      8'h03:   hit = 3'b010;
      8'h07:   hit = 3'b100;
      default: hit = 3'b000;
    endcase
  end

  assign hit_rdy = |(hit & bus.s_ready_i);

  always_comb begin
    hit_rd = '0;
    unique case (1'b1)
      hit[0]:  hit_rd = bus.s0_rd_i;
      hit[1]:  hit_rd = bus.s1_rd_i;
      hit[2]:  hit_rd = bus.s2_rd_i;
      default: hit_rd = '0;
    endcase
  end

  // On a tie the master not served last wins; alone, the requester wins.
  assign win = (bus.m0_req_i && bus.m1_req_i) ? ~last_q : ~bus.m0_req_i;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req_i || bus.m1_req_i) begin
          gnt_d   = win;
          we_d    = win ? bus.m1_we_i   : bus.m0_we_i;
          be_d    = win ? bus.m1_be_i   : bus.m0_be_i;
          addr_d  = win ? bus.m1_addr_i : bus.m0_addr_i;
          wd_d    = win ? bus.m1_wd_i   : bus.m0_wd_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (hit == 3'b000) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (hit_rdy) begin
          rd_d    = hit_rd;
          state_d = RESP;
        end else begin
          state_d = WAIT;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (hit_rdy) begin
          rd_d    = hit_rd;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rd_d    = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        last_d  = gnt_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`endif

  assign resp = (state_q == RESP);
  assign rdy0 = resp & ~gnt_q;
  assign rdy1 = resp & gnt_q;

  assign bus.s_req_o    = (state_q == ACCESS) ? hit : 3'b000;
  assign bus.s_we_o     = we_q;
  assign bus.s_be_o     = be_q;
  assign bus.s_wd_o     = wd_q;
  assign bus.s_addr_o   = {8'h00, addr_q[23:0]};
  assign bus.m0_ready_o = rdy0;
  assign bus.m1_ready_o = rdy1;
  assign bus.m0_rd_o    = rdy0 ? rd_q : '0;
  assign bus.m1_rd_o    = rdy1 ? rd_q : '0;
  assign bus.err_o      = resp & err_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Randomized bench for sys_bus_arbiter against a transaction-level model.
// Build with BUS_TIMEOUT_EN to exercise the abort path (TIMEOUT=4).
module tb_sys_bus_arbiter;

`ifdef BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif
  localparam int TO_P = (TO != 0) ? TO : 255;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sys_bus_arbiter_if bus ();

  sys_bus_arbiter #(.TIMEOUT(TO_P)) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit          pend [2];
  logic        we_a [2];
  logic [3:0]  be_a [2];
  logic [31:0] ad_a [2];
  logic [31:0] wd_a [2];
  int          last_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_masters();
    bus.m0_req_i  = pend[0];
    bus.m0_we_i   = we_a[0];
    bus.m0_be_i   = be_a[0];
    bus.m0_addr_i = ad_a[0];
    bus.m0_wd_i   = wd_a[0];
    bus.m1_req_i  = pend[1];
    bus.m1_we_i   = we_a[1];
    bus.m1_be_i   = be_a[1];
    bus.m1_addr_i = ad_a[1];
    bus.m1_wd_i   = wd_a[1];
  endtask

  task automatic new_req(input int m, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
    pend[m] = 1'b1;
    ad_a[m] = a;
    we_a[m] = w;
    be_a[m] = b;
    wd_a[m] = d;
  endtask

  task automatic slave_drive(input logic [2:0] oh, input bit rdy,
                             input logic [31:0] rdv);
    logic [2:0] noise;
    noise = 3'($urandom) & ~oh;
    bus.s_ready_i = noise | (rdy ? oh : 3'b000);
    bus.s0_rd_i = $urandom;
    bus.s1_rd_i = $urandom;
    bus.s2_rd_i = $urandom;
    if (rdy && oh[0]) bus.s0_rd_i = rdv;
    if (rdy && oh[1]) bus.s1_rd_i = rdv;
    if (rdy && oh[2]) bus.s2_rd_i = rdv;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {20'd0, bus.s_req_o, bus.s_we_o, bus.s_be_o,
                        bus.m0_ready_o, bus.m1_ready_o, bus.err_o}, 32'd0);
    chk({tag, "_rd"}, bus.m0_rd_o | bus.m1_rd_o, 32'd0);
    chk({tag, "_attr"}, bus.s_addr_o | bus.s_wd_o, 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_masters();
    bus.s_ready_i = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    last_m = 1;
  endtask

  // One bus transaction from IDLE; returns one cycle into the next IDLE.
  // lat = cycles after ACCESS at which the slave raises ready.
  task automatic run_txn(input int lat, input logic [31:0] rdv);
    int w;
    logic [2:0] oh;
    bit to;
    int eff;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    w = (pend[0] && pend[1]) ? 1 - last_m : (pend[0] ? 0 : 1);
    case (ad_a[w][31:24])
      8'h00:   oh = 3'b001;
      8'h03:   oh = 3'b010;
      8'h07:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    to  = (TO != 0) && (oh != 3'b000) && (lat > TO);
    eff = (oh == 3'b000) ? 0 : (to ? TO : lat);
    exp_wd   = wd_a[w];
    exp_addr = {8'h00, ad_a[w][23:0]};
    drive_masters();
    @(posedge clk);
    #1;
    chk("acc_sreq", {29'd0, bus.s_req_o}, {29'd0, oh});
    chk("acc_addr", bus.s_addr_o, exp_addr);
    chk("acc_wd", bus.s_wd_o, exp_wd);
    chk("acc_attr", {27'd0, bus.s_we_o, bus.s_be_o}, {27'd0, we_a[w], be_a[w]});
    slave_drive(oh, (oh != 3'b000) && !to && lat == 0, rdv);
    for (int k = 1; k <= eff; k++) begin
      @(posedge clk);
      #1;
      chk("wait_sreq", {29'd0, bus.s_req_o}, 32'd0);
      chk("wait_rdy", {30'd0, bus.m1_ready_o, bus.m0_ready_o}, 32'd0);
      chk("wait_wd", bus.s_wd_o, exp_wd);
      slave_drive(oh, !to && k == lat, rdv);
    end
    @(posedge clk);
    #1;
    exp_rd = (oh == 3'b000) ? 32'd0 : (to ? 32'hDEAD_BEEF : rdv);
    chk("resp_gnt", {30'd0, bus.m1_ready_o, bus.m0_ready_o}, 32'(1 << w));
    chk("resp_rd", w ? bus.m1_rd_o : bus.m0_rd_o, exp_rd);
    chk("resp_rd_other", w ? bus.m0_rd_o : bus.m1_rd_o, 32'd0);
    chk("resp_err", {31'd0, bus.err_o}, {31'd0, (oh == 3'b000) || to});
    chk("resp_addr", bus.s_addr_o, exp_addr);
    pend[w] = 1'b0;
    last_m = w;
    drive_masters();
    slave_drive(oh, to, 32'h0);
    @(posedge clk);
    #1;
    chk("idle_rdy", {29'd0, bus.m1_ready_o, bus.m0_ready_o, bus.err_o}, 32'd0);
    bus.s_ready_i = 3'b000;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] top;
    case ($urandom_range(0, 3))
      0:       top = 8'h00;
      1:       top = 8'h03;
      2:       top = 8'h07;
      default: top = 8'($urandom);
    endcase
    return {top, 24'($urandom)};
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0;
      we_a[m] = 1'b0;
      be_a[m] = 4'h0;
      ad_a[m] = 32'h0;
      wd_a[m] = 32'h0;
    end
    last_m = 1;
    bus.s0_rd_i = '0;
    bus.s1_rd_i = '0;
    bus.s2_rd_i = '0;
    bus.s_ready_i = '0;
    do_reset();

    // single read, minimum latency
    new_req(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    run_txn(0, 32'h1234_5678);

    // contention from reset: grants must alternate m0, m1, ...
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (!pend[0]) new_req(0, {8'h00, 24'($urandom)}, 1'b0, 4'hF, $urandom);
      if (!pend[1]) new_req(1, {8'h00, 24'($urandom)}, 1'b1, 4'h3, $urandom);
      run_txn(0, $urandom);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_masters();
    @(posedge clk);
    #1;

    // slow VGA write
    new_req(1, 32'h0700_0004, 1'b1, 4'b0011, 32'hCAFE_F00D);
    run_txn(3, 32'h0BAD_0BAD);

    // unmapped read
    new_req(0, 32'h0500_0000, 1'b0, 4'hF, 32'h0);
    run_txn(0, 32'h5555_5555);

    // very slow PS/2 (aborts when the timeout is built in)
    new_req(0, 32'h0300_0008, 1'b0, 4'hF, 32'h0);
    run_txn(300, 32'h7777_0001);

    // reset while in WAIT
    new_req(0, 32'h0300_0000, 1'b0, 4'hF, 32'h0);
    drive_masters();
    @(posedge clk);
    #1;
    bus.s_ready_i = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    pend[0] = 1'b0;
    drive_masters();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    last_m = 1;
    new_req(1, 32'h0000_0100, 1'b1, 4'hF, 32'hA5A5_A5A5);
    run_txn(1, 32'h0101_0101);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 2) != 0)
          new_req(m, rand_addr(), 1'($urandom), 4'($urandom), $urandom);
      if (!pend[0] && !pend[1])
        new_req($urandom_range(0, 1), rand_addr(), 1'($urandom),
                4'($urandom), $urandom);
      run_txn($urandom_range(0, 6), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
